// File: rtl/viz_pkg.sv
// Shared definitions for the spectrum visualiser blocks.
// Holds the default band count and bar width, the band-index, bar and level
// types, the IDLE/PUBLISH state enum and the thermometer encoding helper
// used to turn a level into a bar pattern.
package viz_pkg;

  localparam int NUM_BANDS = 16;
  localparam int BAR_WIDTH = 18;

  typedef logic [3:0]           band_idx_t;
  typedef logic [BAR_WIDTH-1:0] bar_t;
  typedef logic [4:0]           level_t;

  typedef enum logic {
    IDLE,
    PUBLISH
  } state_e;

  // Thermometer code: the lowest 'level' segments lit, bit 0 at the bottom.
  // Computed in 32 bits so that a full-height level still yields all ones.
  function automatic bar_t thermo(level_t level);
    logic [31:0] ones;
    ones = (32'd1 << level) - 32'd1;
    return ones[BAR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/level_quantizer.sv
// Combinational priority encoder from an unsigned magnitude to a bar level.
// The level is the position of the highest set bit plus one, so zero maps to
// level 0 and a value with the top bit set maps to MAG_WIDTH.
// Ports:
//   mag_data  in  MAG_WIDTH  unsigned magnitude
//   level     out 5          quantized level, 0..MAG_WIDTH
module level_quantizer
  import viz_pkg::*;
#(
  parameter int MAG_WIDTH = 18
) (
  input  logic [MAG_WIDTH-1:0] mag_data,
  output level_t               level
);

  // Scan upward so the highest set bit is the last one to overwrite level.
  always_comb begin
    level = '0;
    for (int i = 0; i < MAG_WIDTH; i++) begin
      if (mag_data[i]) begin
        level = level_t'(i + 1);
      end
    end
  end

endmodule

// File: rtl/spectrum_bar_encoder.sv
// Turns per-band spectrum magnitudes into thermometer bar patterns for the
// VGA display. Peaks are accumulated per band during a frame; on each frame
// tick every bar is published one band per cycle, and each band level is then
// decayed, so bars jump up at once and fall back slowly.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   mag_valid       magnitude sample present
//   mag_ready       block can accept a sample (low while publishing)
//   mag_band        band index of the sample
//   mag_data        unsigned magnitude of the sample
//   frame_tick      one-cycle pulse at the start of vertical blanking
//   bars            registered bar patterns, bit 0 is the bottom segment
//   bars_update     one-cycle pulse after the last bar has been written
//   frame_overrun   sticky flag: a frame tick arrived while publishing
module spectrum_bar_encoder #(
  parameter int NUM_BANDS = viz_pkg::NUM_BANDS,
  parameter int BAR_WIDTH = viz_pkg::BAR_WIDTH,
  parameter int MAG_WIDTH = viz_pkg::BAR_WIDTH,
  parameter int DECAY     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mag_valid,
  output logic                                mag_ready,
  input  logic [3:0]                          mag_band,
  input  logic [MAG_WIDTH-1:0]                mag_data,
  input  logic                                frame_tick,
  output logic [NUM_BANDS-1:0][BAR_WIDTH-1:0] bars,
  output logic                                bars_update,
  output logic                                frame_overrun
);
  import viz_pkg::*;

  state_e    r_state;
  state_e    w_nextState;
  band_idx_t r_idx;
  band_idx_t w_nextIdx;
  level_t    r_lvl [NUM_BANDS];
  level_t    w_sampleLevel;
  logic      w_accept;
  logic      w_lastIdx;

  logic [NUM_BANDS-1:0][BAR_WIDTH-1:0] r_bars;
  logic                                r_barsUpdate;
  logic                                r_overrun;

  // Saturating per-frame decay of a band level.
  function automatic level_t decayLevel(level_t lvl);
    if (int'(lvl) > DECAY) begin
      return level_t'(int'(lvl) - DECAY);
    end
    return '0;
  endfunction

  level_quantizer #(
    .MAG_WIDTH (MAG_WIDTH)
  ) u_quantizer (
    .mag_data (mag_data),
    .level    (w_sampleLevel)
  );

  assign mag_ready = (r_state == IDLE);
  assign w_lastIdx = (int'(r_idx) == NUM_BANDS - 1);
  // Band indices beyond the configured band count are accepted but dropped.
  assign w_accept  = mag_valid && mag_ready && (int'(mag_band) < NUM_BANDS);

  // State and publish index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
    end
  end

  // Next state: a frame tick in IDLE starts a walk over all bands; ticks that
  // arrive during that walk do not queue another publish.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_nextState = PUBLISH;
          w_nextIdx   = '0;
        end
      end
      PUBLISH: begin
        if (w_lastIdx) begin
          w_nextState = IDLE;
        end else begin
          w_nextIdx = r_idx + band_idx_t'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Level accumulation, publishing and status flags. Samples only land in
  // IDLE, so a sample taken together with a frame tick is already merged
  // when the publish reads that band, and never collides with the decay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_lvl[b] <= '0;
      end
      r_bars       <= '0;
      r_barsUpdate <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_barsUpdate <= 1'b0;
      if (w_accept && (w_sampleLevel > r_lvl[mag_band])) begin
        r_lvl[mag_band] <= w_sampleLevel;
      end
      if (r_state == PUBLISH) begin
        r_bars[r_idx] <= thermo(r_lvl[r_idx]);
        r_lvl[r_idx]  <= decayLevel(r_lvl[r_idx]);
        r_barsUpdate  <= w_lastIdx;
        if (frame_tick) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign bars          = r_bars;
  assign bars_update   = r_barsUpdate;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_spectrum_bar_encoder.sv
// Directed testbench for spectrum_bar_encoder. Inputs change and outputs are
// sampled on the falling clock edge; every expected bar value is written out
// by hand from the magnitudes sent in each scenario.
module tb_spectrum_bar_encoder;

  logic              clk;
  logic              rst;
  logic              mag_valid;
  logic              mag_ready;
  logic [3:0]        mag_band;
  logic [17:0]       mag_data;
  logic              frame_tick;
  logic [15:0][17:0] bars;
  logic              bars_update;
  logic              frame_overrun;

  int          testsRun;
  int          failCount;
  logic [17:0] expBars [16];

  spectrum_bar_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .mag_valid     (mag_valid),
    .mag_ready     (mag_ready),
    .mag_band      (mag_band),
    .mag_data      (mag_data),
    .frame_tick    (frame_tick),
    .bars          (bars),
    .bars_update   (bars_update),
    .frame_overrun (frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllBars(input string tag);
    for (int b = 0; b < 16; b++) begin
      checkOutput($sformatf("%s bars[%0d]", tag, b), 32'(bars[b]), 32'(expBars[b]));
    end
  endtask

  task automatic clearExpected();
    for (int b = 0; b < 16; b++) begin
      expBars[b] = '0;
    end
  endtask

  // Single-cycle sample handshake; the block is in IDLE so it is accepted.
  task automatic applyStimulus(input logic [3:0] band, input logic [17:0] data);
    @(negedge clk);
    mag_valid = 1'b1;
    mag_band  = band;
    mag_data  = data;
    @(negedge clk);
    mag_valid = 1'b0;
    mag_data  = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearExpected();
  endtask

  // Pulses frame_tick and waits (bounded) for bars_update. cycles counts the
  // clock edges after the edge that sampled the tick; lowCycles counts the
  // cycles mag_ready was low along the way.
  task automatic runFrame(input string tag, output int cycles, output int lowCycles);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cycles    = 0;
    lowCycles = 0;
    while (bars_update !== 1'b1 && cycles < 40) begin
      if (mag_ready === 1'b0) lowCycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " bars_update seen"}, 32'(bars_update), 32'd1);
  endtask

  int cyc;
  int low;
  int pulses;

  initial begin
    testsRun   = 0;
    failCount  = 0;
    rst        = 1'b1;
    mag_valid  = 1'b0;
    mag_band   = '0;
    mag_data   = '0;
    frame_tick = 1'b0;
    clearExpected();
    #12;

    // Reset state
    checkAllBars("reset");
    checkOutput("reset mag_ready", 32'(mag_ready), 32'd1);
    checkOutput("reset bars_update", 32'(bars_update), 32'd0);
    checkOutput("reset frame_overrun", 32'(frame_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single band quantization: 0x100 -> level 9
    applyStimulus(4'd3, 18'h00100);
    runFrame("single", cyc, low);
    expBars[3] = 18'h001FF;
    checkAllBars("single");

    // Extremes, including a zero sample
    resetDut();
    applyStimulus(4'd0, 18'h00001);
    applyStimulus(4'd7, 18'h3FFFF);
    applyStimulus(4'd5, 18'h00000);
    runFrame("extremes", cyc, low);
    expBars[0] = 18'h00001;
    expBars[7] = 18'h3FFFF;
    checkAllBars("extremes");

    // Peak merge then decay to zero: level 5 -> 4,3,2,1,0,0
    resetDut();
    applyStimulus(4'd2, 18'h00010);
    applyStimulus(4'd2, 18'h00003);
    runFrame("merge", cyc, low);
    checkOutput("merge bars[2]", 32'(bars[2]), 32'h1F);
    // A sample in IDLE must not move the published bars
    applyStimulus(4'd2, 18'h00002);
    checkOutput("idle stable bars[2]", 32'(bars[2]), 32'h1F);
    runFrame("decay1", cyc, low);
    checkOutput("decay1 bars[2]", 32'(bars[2]), 32'h0F);
    runFrame("decay2", cyc, low);
    checkOutput("decay2 bars[2]", 32'(bars[2]), 32'h07);
    runFrame("decay3", cyc, low);
    checkOutput("decay3 bars[2]", 32'(bars[2]), 32'h03);
    runFrame("decay4", cyc, low);
    checkOutput("decay4 bars[2]", 32'(bars[2]), 32'h01);
    runFrame("decay5", cyc, low);
    checkOutput("decay5 bars[2]", 32'(bars[2]), 32'h00);
    runFrame("decay6", cyc, low);
    checkOutput("decay6 bars[2]", 32'(bars[2]), 32'h00);

    // Sample coincident with frame_tick belongs to the closing frame
    resetDut();
    @(negedge clk);
    mag_valid  = 1'b1;
    mag_band   = 4'd1;
    mag_data   = 18'h00080;
    frame_tick = 1'b1;
    @(negedge clk);
    mag_valid  = 1'b0;
    mag_data   = '0;
    frame_tick = 1'b0;
    cyc = 0;
    low = 0;
    while (bars_update !== 1'b1 && cyc < 40) begin
      if (mag_ready === 1'b0) low++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("coincident bars_update seen", 32'(bars_update), 32'd1);
    checkOutput("coincident update edges after tick edge", 32'(cyc), 32'd16);
    checkOutput("coincident mag_ready low cycles", 32'(low), 32'd16);
    checkOutput("coincident ready at update", 32'(mag_ready), 32'd1);
    // Sample accepted on the edge that ends the bars_update cycle
    mag_valid = 1'b1;
    mag_band  = 4'd4;
    mag_data  = 18'h00004;
    @(negedge clk);
    mag_valid = 1'b0;
    mag_data  = '0;
    checkOutput("coincident bars_update one cycle", 32'(bars_update), 32'd0);
    expBars[1] = 18'h000FF;
    checkAllBars("coincident");
    runFrame("next frame", cyc, low);
    expBars[1] = 18'h0007F;
    expBars[4] = 18'h00007;
    checkAllBars("next frame");

    // Overrun: second tick at publish index 5
    resetDut();
    applyStimulus(4'd11, 18'h00008);
    checkOutput("overrun before", 32'(frame_overrun), 32'd0);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) frame_tick = 1'b1;
      if (i == 6) frame_tick = 1'b0;
      if (bars_update === 1'b1) pulses++;
      @(negedge clk);
    end
    checkOutput("overrun pulse count", 32'(pulses), 32'd1);
    checkOutput("overrun flag", 32'(frame_overrun), 32'd1);
    checkOutput("overrun bars[11]", 32'(bars[11]), 32'h0F);
    runFrame("after overrun", cyc, low);
    checkOutput("overrun sticky", 32'(frame_overrun), 32'd1);
    checkOutput("after overrun bars[11]", 32'(bars[11]), 32'h07);

    // Reset in the middle of a publish
    resetDut();
    applyStimulus(4'd6, 18'h00FFF);
    runFrame("pre reset", cyc, low);
    checkOutput("pre reset bars[6]", 32'(bars[6]), 32'hFFF);
    applyStimulus(4'd9, 18'h00020);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    clearExpected();
    checkAllBars("mid reset");
    checkOutput("mid reset mag_ready", 32'(mag_ready), 32'd1);
    checkOutput("mid reset overrun", 32'(frame_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd10, 18'h00002);
    runFrame("post reset", cyc, low);
    expBars[10] = 18'h00003;
    checkAllBars("post reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
